// File: rtl/shared_adder_sched.sv
// Round-robin scheduler sharing one 4-bit adder slice among NREQ requesters.
// Wide sums are built one nibble per cycle through a registered carry.
module shared_adder_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id
);

  localparam int unsigned K  = WIDTH / 4;
  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;

  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       nib_sum;
  logic             last_nib;
  logic             grant;

  // First valid requester at or after last+1, wrapping around.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (32'(last_q) + off) % NREQ;
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(cand);
      end
    end
  end

  assign grant = (state_q == IDLE) && gnt_found;

  // Gated by rst so no grant is offered while the block is held in reset.
  always_comb begin
    req_ready = '0;
    if (grant && !rst) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign a_nib    = a_q[{cnt_q, 2'b00} +: 4];
  assign b_nib    = b_q[{cnt_q, 2'b00} +: 4];
  assign nib_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  assign last_nib = (cnt_q == CW'(K - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (gnt_found) state_d = RUN;
      RUN:  if (last_nib) state_d = DONE;
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IDW'(NREQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        a_q     <= req_a[gnt_idx*WIDTH +: WIDTH];
        b_q     <= req_b[gnt_idx*WIDTH +: WIDTH];
        id_q    <= gnt_idx;
        last_q  <= gnt_idx;
        cnt_q   <= '0;
        carry_q <= 1'b0;
      end else if (state_q == RUN) begin
        sum_q[{cnt_q, 2'b00} +: 4] <= nib_sum[3:0];
        carry_q                    <= nib_sum[4];
        cnt_q                      <= last_nib ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_shared_adder_sched.sv
// Bench for shared_adder_sched: directed vector table, reset/spacing sequences,
// and randomized transactions against a round-robin / plain-arithmetic model.
module tb_shared_adder_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;
  localparam int K     = WIDTH / 4;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;

  shared_adder_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int m_last = NREQ - 1;

  typedef struct {
    logic [3:0]  mask;
    logic [15:0] a;
    logic [15:0] b;
    int          id;
    logic [16:0] res;
    int          stall;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Round-robin rule: first set bit searching from last+1 with wrap.
  function automatic int model_grant(input logic [3:0] mask, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int c;
      c = (last + off) % NREQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  // Entered #1 after an edge with the DUT idle; leaves #1 after the next idle-starting edge.
  task automatic run_txn(input logic [3:0] mask, input logic [63:0] av, input logic [63:0] bv,
                         input int exp_id, input logic [16:0] exp_res, input int stall,
                         output int gcyc);
    logic [3:0] exp_rdy;
    gcyc      = -1;
    req_valid = mask;
    req_a     = av;
    req_b     = bv;
    rsp_ready = 1'($urandom_range(0, 1));
    exp_rdy   = (exp_id < 0) ? 4'b0000 : (4'b0001 << exp_id);
    #3;
    chk("grant", 64'(req_ready), 64'(exp_rdy));
    chk("idle_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    gcyc = cyc;
    #1;
    if (exp_id < 0) begin
      req_valid = '0;
      return;
    end
    m_last = exp_id;
    // Operand changes after the grant edge must not affect the result.
    req_a     = {$urandom, $urandom};
    req_b     = {$urandom, $urandom};
    req_valid = 4'($urandom_range(0, 15));
    for (int j = 0; j < K; j++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      #3;
      chk("run_valid", 64'(rsp_valid), 64'd0);
      chk("run_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    for (int s = 0; s <= stall; s++) begin
      rsp_ready = (s == stall);
      #3;
      chk("done_valid", 64'(rsp_valid), 64'd1);
      chk("done_sum", 64'(rsp_sum), 64'(exp_res[15:0]));
      chk("done_cout", 64'(rsp_cout), 64'(exp_res[16]));
      chk("done_id", 64'(rsp_id), 64'(exp_id));
      chk("done_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;
    req_valid = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdy"}, 64'(req_ready), 64'd0);
    chk({tag, "_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_sum"}, 64'(rsp_sum), 64'd0);
    chk({tag, "_cout"}, 64'(rsp_cout), 64'd0);
    chk({tag, "_id"}, 64'(rsp_id), 64'd0);
  endtask

  initial begin
    int gc;
    int gcs[5];

    tbl[0] = '{4'b0100, 16'hFFFF, 16'h0001, 2, 17'h1_0000, 0};
    tbl[1] = '{4'b0001, 16'h0FFF, 16'h0001, 0, 17'h0_1000, 0};
    tbl[2] = '{4'b1111, 16'h1234, 16'h4321, 1, 17'h0_5555, 0};
    tbl[3] = '{4'b1010, 16'h8000, 16'h8000, 3, 17'h1_0000, 0};
    tbl[4] = '{4'b1010, 16'hABCD, 16'h1111, 1, 17'h0_BCDE, 10};
    tbl[5] = '{4'b1010, 16'h0F0F, 16'h00F1, 3, 17'h0_1000, 0};
    tbl[6] = '{4'b1010, 16'h7FFF, 16'h0001, 1, 17'h0_8000, 2};
    tbl[7] = '{4'b0101, 16'hFFFF, 16'hFFFF, 2, 17'h1_FFFE, 0};
    tbl[8] = '{4'b1001, 16'h0001, 16'h0002, 3, 17'h0_0003, 1};
    tbl[9] = '{4'b0000, 16'h5555, 16'h5555, -1, 17'h0_0000, 0};

    rst       = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;

    foreach (tbl[i]) begin
      run_txn(tbl[i].mask, {4{tbl[i].a}}, {4{tbl[i].b}}, tbl[i].id, tbl[i].res,
              tbl[i].stall, gc);
    end

    // Reset during the second RUN cycle of a grant to requester 0.
    req_valid = 4'b0001;
    req_a     = {4{16'h1111}};
    req_b     = {4{16'h2222}};
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    m_last    = NREQ - 1;
    for (int j = 0; j < 6; j++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      #3;
      chk("post_rst_valid", 64'(rsp_valid), 64'd0);
      chk("post_rst_ready", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b0;

    // All requesters held valid: order 0,1,2,3,0 at K+2 cycle spacing.
    for (int g = 0; g < 5; g++) begin
      logic [63:0] av, bv;
      logic [15:0] sa, sb;
      int ei;
      av = {$urandom, $urandom};
      bv = {$urandom, $urandom};
      ei = g % NREQ;
      sa = av[ei*16 +: 16];
      sb = bv[ei*16 +: 16];
      run_txn(4'b1111, av, bv, ei, {1'b0, sa} + {1'b0, sb}, 0, gc);
      gcs[g] = gc;
    end
    for (int g = 1; g < 5; g++) chk("grant_spacing", 64'(gcs[g] - gcs[g-1]), 64'(K + 2));

    // Randomized transactions against the round-robin + arithmetic model.
    for (int t = 0; t < 40; t++) begin
      logic [63:0] av, bv;
      logic [3:0]  mask;
      logic [16:0] res;
      int gid;
      mask = 4'($urandom_range(0, 15));
      av   = {$urandom, $urandom};
      bv   = {$urandom, $urandom};
      gid  = model_grant(mask, m_last);
      res  = '0;
      if (gid >= 0) res = {1'b0, av[gid*16 +: 16]} + {1'b0, bv[gid*16 +: 16]};
      run_txn(mask, av, bv, gid, res, $urandom_range(0, 3), gc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shared_adder_sched.md
# shared_adder_sched

Nibble-serial add scheduler that shares one 4-bit adder slice among NREQ requesters. Round-robin arbitration picks a requester and latches its WIDTH-bit operand pair. The block then computes the sum 4 bits per cycle, carrying between nibbles through a registered carry, and returns sum, carry-out and requester id over a valid/ready response channel. It sits between client blocks needing occasional wide additions and the single small adder datapath, trading latency for area.

## Interface
- NREQ, 4: number of requesters; legal 2..8.
- WIDTH, 16: operand width; multiple of 4, ≥4. K = WIDTH/4 nibble cycles.
- IDW, $clog2(NREQ): requester id width.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has an operand pair.
- req_ready  out  NREQ  one-hot grant/accept; at most one bit high.
- req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  WIDTH  A+B modulo 2^WIDTH.
- rsp_cout  out  1  carry out of top nibble.
- rsp_id  out  IDW  index of requester that produced the result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - req_ready is combinational.
  - The grant goes to the first i with req_valid[i], searching from (last+1) mod NREQ with wrap.
  - On grant: latch a, b and id. Clear the nibble counter and carry to 0. Record last=i. Go to RUN.
  - No valid requests: stay in IDLE, req_ready=0.
- RUN:
  - Each cycle adds nibble n of A, nibble n of B and the carry register as a 5-bit add.
  - Low 4 bits are written to result[4n+3:4n]; bit 4 is written to the carry register; n increments.
  - After nibble K-1 is written, go to DONE. The final carry becomes rsp_cout.
- DONE:
  - rsp_valid=1.
  - rsp_sum, rsp_cout and rsp_id are held stable until rsp_ready=1.
  - On handshake, go to IDLE.
- req_ready=0 in RUN and DONE. No new operand is accepted until the response is consumed.
- A requester may withdraw req_valid before being granted; the arbiter re-evaluates every IDLE cycle. Operands are sampled only on the grant edge; later changes are ignored.
- The round-robin pointer advances only on a grant. A requester that is not valid is skipped without consuming a turn.
- Reset values:
  - State IDLE; last=NREQ-1, so requester 0 has priority first.
  - Counter, carry, result, id all 0.
  - Outputs: req_ready=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0.
- Reset asserted mid-RUN or in DONE aborts immediately. The pending result is discarded, no response is produced, and the pointer returns to its reset value.

## Timing
- Grant handshake at edge T (req_valid[i] & req_ready[i] high in the cycle ending at T).
- RUN occupies cycles T..T+K-1, one nibble per cycle.
- rsp_valid rises in the cycle after edge T+K-1, i.e. K cycles after the grant edge.
- Response handshake at edge R puts the FSM in IDLE for the next cycle. The earliest next grant edge is R+1 (one bubble cycle).
- Minimum period per operation: K+2 cycles. For WIDTH=16 that is 6 cycles.
- rsp_* outputs are registered; req_ready is combinational from req_valid, state and pointer.
- rsp_ready has no effect outside DONE.

## Test plan
- Single request, WIDTH=16, requester 2, a=0xFFFF, b=0x0001 -> one req_ready[2] pulse; rsp_valid 4 cycles after grant; rsp_sum=0x0000, rsp_cout=1, rsp_id=2.
- Inter-nibble carry: a=0x0FFF, b=0x0001 -> rsp_sum=0x1000, rsp_cout=0. Also a=0x1234, b=0x4321 -> rsp_sum=0x5555, rsp_cout=0.
- All four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0. Each result carries the matching id and sum; 6-cycle spacing between grants.
- Sparse round-robin: only requesters 1 and 3 valid -> grants alternate 1,3,1,3. req_ready is never high for 0 or 2.
- Backpressure: rsp_ready=0 for 10 cycles in DONE -> rsp_valid, rsp_sum and rsp_id stay constant; req_ready stays all-zero; the single handshake then returns to IDLE.
- Reset mid-operation: assert rst during the second RUN cycle -> all outputs 0 within the reset cycle, no rsp_valid after release. The first grant after release goes to requester 0 even if requester 0 was just served.
